// File: rtl/vend_controller.sv
// vend_controller: central sequencer of the vending machine.
// Accumulates coin credit, authorises a vend when credit covers ITEM_PRICE,
// then pays change greedily (25/10/5) one coin per accepted hopper cycle.
// Optional feature macro: CREDIT_TIMEOUT_EN (idle refund after TIMEOUT_CYCLES
// cycles in CREDIT). Without it no timeout counter is built.
//
// Hopper handshake: a change_* pulse is a coin command. It is issued only in a
// cycle following one in which change_ready was sampled high while in CHANGE;
// with change_ready low the controller holds state and credit unchanged.
module vend_controller #(
  parameter int ITEM_PRICE     = 65,
  parameter int MAX_CREDIT     = 100,
  parameter int CREDIT_W       = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pulse_5,
  input  logic                pulse_10,
  input  logic                pulse_25,
  input  logic                select,
  input  logic                cancel,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_25,
  output logic                change_10,
  output logic                change_5,
  output logic                coin_reject,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(ITEM_PRICE);
  localparam logic [CREDIT_W-1:0] C25     = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(5);

  state_t              state_q, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic                disp_n, c25_n, c10_n, c5_n, rej_n, busy_n;
  logic                coin_any, coin_ok, timeout_hit;
  logic [CREDIT_W:0]   coin_sum, total;
  logic [CREDIT_W-1:0] pay;

  assign dbg_state = state_q;
  assign coin_any  = pulse_5 | pulse_10 | pulse_25;

  // Coin sum and prospective credit, one bit wider so overflow compares cleanly.
  always_comb begin
    coin_sum = '0;
    if (pulse_5)  coin_sum = coin_sum + (CREDIT_W+1)'(5);
    if (pulse_10) coin_sum = coin_sum + (CREDIT_W+1)'(10);
    if (pulse_25) coin_sum = coin_sum + (CREDIT_W+1)'(25);
    total = {1'b0, credit} + coin_sum;
  end

`ifdef CREDIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_n;

  assign timeout_hit = (state_q == S_CREDIT) && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Timer runs only while staying in CREDIT; activity or entry restarts it.
  always_comb begin
    timer_n = timer_q + TW'(1);
    if (state_q != S_CREDIT || state_n != S_CREDIT || coin_ok || select)
      timer_n = '0;
  end

  // Timer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer_q <= '0;
    else        timer_q <= timer_n;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, next-credit and next-output decode.
  always_comb begin
    state_n  = state_q;
    credit_n = credit;
    disp_n   = 1'b0;
    c25_n    = 1'b0;
    c10_n    = 1'b0;
    c5_n     = 1'b0;
    rej_n    = 1'b0;
    coin_ok  = 1'b0;
    pay      = '0;
    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (state_q == S_CREDIT && cancel) begin
          // Full credit becomes the refund; coins this cycle bounce.
          state_n = S_CHANGE;
          rej_n   = coin_any;
        end else if (state_q == S_CREDIT && select && credit >= PRICE_C) begin
          credit_n = credit - PRICE_C;
          disp_n   = 1'b1;
          state_n  = S_VEND;
          rej_n    = coin_any;
        end else if (timeout_hit) begin
          state_n = S_CHANGE;
          rej_n   = coin_any;
        end else if (coin_any) begin
          if (total <= MAX_C) begin
            credit_n = total[CREDIT_W-1:0];
            state_n  = S_CREDIT;
            coin_ok  = 1'b1;
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      S_VEND: begin
        rej_n   = coin_any;
        state_n = (credit != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        rej_n = coin_any;
        if (credit == '0) begin
          state_n = S_IDLE;
        end else if (change_ready) begin
          if (credit >= C25) begin
            c25_n = 1'b1;
            pay   = C25;
          end else if (credit >= C10) begin
            c10_n = 1'b1;
            pay   = C10;
          end else begin
            c5_n = 1'b1;
            pay  = C5;
          end
          credit_n = credit - pay;
          if (credit_n == '0) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_VEND) || (state_n == S_CHANGE);
  end

  // State and registered outputs; reset aborts any vend or payout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      credit      <= '0;
      dispense    <= 1'b0;
      change_25   <= 1'b0;
      change_10   <= 1'b0;
      change_5    <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      credit      <= credit_n;
      dispense    <= disp_n;
      change_25   <= c25_n;
      change_10   <= c10_n;
      change_5    <= c5_n;
      coin_reject <= rej_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: table of {inputs, expected outputs} vectors,
// expected values queued when driven and popped when the outputs are sampled,
// plus hand-written sequences for the ready wait and reset abort.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pulse_5 = 1'b0, pulse_10 = 1'b0, pulse_25 = 1'b0;
  logic       select = 1'b0, cancel = 1'b0, change_ready = 1'b0;
  logic [7:0] credit;
  logic       dispense, change_25, change_10, change_5, coin_reject, busy;
  logic [1:0] dbg_state;

  vend_controller #(
    .ITEM_PRICE(65), .MAX_CREDIT(100), .CREDIT_W(8), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset),
    .pulse_5(pulse_5), .pulse_10(pulse_10), .pulse_25(pulse_25),
    .select(select), .cancel(cancel), .change_ready(change_ready),
    .credit(credit), .dispense(dispense), .change_25(change_25),
    .change_10(change_10), .change_5(change_5), .coin_reject(coin_reject),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // in  = {p5, p10, p25, sel, cancel, ready}
  // out = {dispense, c25, c10, c5, reject, busy}; exp = {credit, out}
  typedef struct {
    string      name;
    logic [5:0] in;
    logic [13:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void add(string n, logic [5:0] in, int cr, logic [5:0] o);
    vec_t v;
    v.name = n;
    v.in   = in;
    v.exp  = {8'(cr), o};
    vecs.push_back(v);
  endfunction

  function automatic logic [13:0] act_vec();
    return {credit, dispense, change_25, change_10, change_5, coin_reject, busy};
  endfunction

  task automatic check(string n);
    logic [13:0] e, a;
    a = act_vec();
    e = exp_q.pop_front();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got credit=%0d flags(d,25,10,5,rej,busy)=%b, expected credit=%0d flags=%b",
               n, a[13:6], a[5:0], e[13:6], e[5:0]);
    end
  endtask

  task automatic drive(vec_t v);
    @(negedge clk);
    {pulse_5, pulse_10, pulse_25, select, cancel, change_ready} = v.in;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(v.name);
  endtask

  task automatic run_table();
    foreach (vecs[i]) drive(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    int waited;
    // 1: buy with 70, one 5c of change
    add("t1_q25a", 6'b001000, 25, 6'b000000);
    add("t1_q25b", 6'b001000, 50, 6'b000000);
    add("t1_d10a", 6'b010000, 60, 6'b000000);
    add("t1_d10b", 6'b010000, 70, 6'b000000);
    add("t1_sel",  6'b000101,  5, 6'b100001);
    add("t1_vend", 6'b000001,  5, 6'b000001);
    add("t1_c5",   6'b000001,  0, 6'b000100);
    add("t1_idle", 6'b000001,  0, 6'b000000);
    // 2: cancel 40 -> 25, 10, 5
    add("t2_q25",  6'b001000, 25, 6'b000000);
    add("t2_d10",  6'b010000, 35, 6'b000000);
    add("t2_n5",   6'b100000, 40, 6'b000000);
    add("t2_can",  6'b000011, 40, 6'b000001);
    add("t2_c25",  6'b000001, 15, 6'b010001);
    add("t2_c10",  6'b000001,  5, 6'b001001);
    add("t2_c5",   6'b000001,  0, 6'b000100);
    // 3: ceiling reject, then buy at 100 -> 35 change
    for (int i = 1; i <= 4; i++) add("t3_q25", 6'b001000, 25 * i, 6'b000000);
    add("t3_over", 6'b100000, 100, 6'b000010);
    add("t3_sel",  6'b000101,  35, 6'b100001);
    add("t3_vend", 6'b000001,  35, 6'b000001);
    add("t3_c25",  6'b000001,  10, 6'b010001);
    add("t3_c10",  6'b000001,   0, 6'b001000);
    // 4: refund held by ready low
    add("t4_q25",  6'b001000, 25, 6'b000000);
    add("t4_can",  6'b000010, 25, 6'b000001);
    for (int i = 0; i < 10; i++) add("t4_hold", 6'b000000, 25, 6'b000001);
    add("t4_c25",  6'b000001,  0, 6'b010000);
    // 5: select short of price, cancel with a coin in the same cycle
    add("t5_q25a", 6'b001000, 25, 6'b000000);
    add("t5_q25b", 6'b001000, 50, 6'b000000);
    add("t5_d10",  6'b010000, 60, 6'b000000);
    add("t5_sel",  6'b000100, 60, 6'b000000);
    add("t5_canc", 6'b010010, 60, 6'b000011);
    add("t5_c25a", 6'b000001, 35, 6'b010001);
    add("t5_c25b", 6'b000001, 10, 6'b010001);
    add("t5_c10",  6'b000001,  0, 6'b001000);
    // 6: simultaneous coins, then refund of 35
    add("t6_sum",  6'b011000, 35, 6'b000000);
`ifdef CREDIT_TIMEOUT_EN
    for (int i = 0; i < 19; i++) add("t6_wait", 6'b000000, 35, 6'b000000);
    add("t6_tmo",  6'b000000, 35, 6'b000001);
`else
    add("t6_can",  6'b000011, 35, 6'b000001);
`endif
    add("t6_c25",  6'b000001, 10, 6'b010001);
    add("t6_c10",  6'b000001,  0, 6'b001000);
    // coin during VEND is rejected and does not add credit
    add("t8_q25a", 6'b001000, 25, 6'b000000);
    add("t8_q25b", 6'b001000, 50, 6'b000000);
    add("t8_q25c", 6'b001000, 75, 6'b000000);
    add("t8_sel",  6'b000100, 10, 6'b100001);
    add("t8_vcoin",6'b001000, 10, 6'b000011);
    add("t8_c10",  6'b000001,  0, 6'b001000);

    // Reset.
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(14'd0);
    check("reset");
    @(negedge clk);
    reset = 1'b1;

    run_table();

    // 7: bounded wait for the hopper payout after ready rises.
    add("t7_d10", 6'b010000, 10, 6'b000000);
    add("t7_can", 6'b000010, 10, 6'b000001);
    run_table();
    @(negedge clk);
    {pulse_5, pulse_10, pulse_25, select, cancel} = '0;
    change_ready = 1'b1;
    waited = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      waited++;
      if (change_10) break;
    end
    n_cmp++;
    if (!(change_10 === 1'b1 && waited == 1 && credit === 8'd0)) begin
      n_bad++;
      $display("FAIL t7_wait: got change_10=%b after %0d cycles credit=%0d, expected 1 after 1 cycle credit=0",
               change_10, waited, credit);
    end

    // Reset asserted mid-CHANGE aborts and discards pending change.
    add("t9_q25", 6'b001000, 25, 6'b000000);
    add("t9_can", 6'b000010, 25, 6'b000001);
    run_table();
    @(negedge clk);
    change_ready = 1'b0;
    reset = 1'b0;
    #1;
    exp_q.push_back(14'd0);
    check("t9_abort");
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL t9_state: got state=%0d, expected 0", dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    add("t9_after", 6'b000001, 0, 6'b000000);
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Central sequencer for the retro vending machine. Consumes the single-cycle, edge-detected coin pulses for 5¢, 10¢ and 25¢ and the user select/cancel pulses. Accumulates credit, authorises a vend when credit covers the price, then pays out change one coin at a time through a ready-gated coin hopper. Sits between the coin edge detectors and the dispense/hopper actuators.

Parameters:
ITEM_PRICE, 65, item price in cents; multiple of 5, ≤ MAX_CREDIT
MAX_CREDIT, 100, credit ceiling in cents; multiple of 5, < 2^CREDIT_W
CREDIT_W, 8, width of the credit register in bits
TIMEOUT_CYCLES, 1000, idle-refund timeout; used only with CREDIT_TIMEOUT_EN

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
pulse_5  input  1  one-cycle pulse, 5¢ coin inserted
pulse_10  input  1  one-cycle pulse, 10¢ coin inserted
pulse_25  input  1  one-cycle pulse, 25¢ coin inserted
select  input  1  one-cycle pulse, purchase request
cancel  input  1  one-cycle pulse, refund request
change_ready  input  1  hopper can accept a coin command this cycle
credit  output  CREDIT_W  current credit in cents, registered
dispense  output  1  one-cycle pulse, release item
change_25  output  1  one-cycle pulse, eject 25¢
change_10  output  1  one-cycle pulse, eject 10¢
change_5  output  1  one-cycle pulse, eject 5¢
coin_reject  output  1  one-cycle pulse, inserted coin(s) routed to return chute
busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset (reset=0): state IDLE. credit=0; dispense, change_*, coin_reject=0; busy=0; timeout counter=0. Reset asserted mid-VEND or mid-CHANGE aborts immediately. Pending change is discarded.
- All outputs are registered. An input event in cycle N is visible on outputs in cycle N+1.
- States: IDLE (credit==0), CREDIT (credit>0, awaiting user), VEND, CHANGE.
- Coin sum = 5*pulse_5 + 10*pulse_10 + 25*pulse_25. Multiple pulses in one cycle are summed.
- Coin acceptance, IDLE/CREDIT only:
  - If credit+sum ≤ MAX_CREDIT: credit += sum; IDLE→CREDIT.
  - Otherwise the whole sum is rejected: coin_reject=1 for one cycle; credit unchanged.
- Coins arriving in VEND/CHANGE, or in the same cycle as an accepted select or cancel, are rejected (coin_reject pulse) and do not change credit.
- Priority in CREDIT: cancel > select > coins.
- cancel in CREDIT: CREDIT→CHANGE, credit retained as the refund amount. cancel in IDLE: ignored.
- select in CREDIT:
  - If credit ≥ ITEM_PRICE: credit -= ITEM_PRICE; dispense=1 next cycle; state VEND.
  - If credit < ITEM_PRICE: select is ignored; no output change.
  - select in IDLE: ignored.
- VEND lasts exactly one cycle (the dispense pulse). Next state: CHANGE if credit>0, else IDLE.
- CHANGE, each cycle:
  - change_ready=0: hold; no pulse; credit unchanged.
  - change_ready=1: greedy payout. Pulse change_25 if credit≥25, else change_10 if credit≥10, else change_5. Subtract that value from credit.
  - At most one change_* pulse per cycle.
  - When credit reaches 0: →IDLE, busy falls the following cycle.
- Credit is always a multiple of 5, so payout terminates; it never underflows.
- select and cancel in VEND/CHANGE are ignored.
- Arithmetic: sums are computed at CREDIT_W+1 bits before the MAX_CREDIT compare; credit never exceeds MAX_CREDIT.

Optional Feature:
- Macro: CREDIT_TIMEOUT_EN.
- Defined: a counter runs in CREDIT. It clears on any accepted coin, any select, and on entering CREDIT. When it reaches TIMEOUT_CYCLES-1, the controller forces CREDIT→CHANGE and refunds the full credit, exactly as cancel does. The counter is held at 0 outside CREDIT.
- Undefined: no counter is built; CREDIT persists indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
1. Reset, then pulse_25, pulse_25, pulse_10, pulse_10 (credit 70), then select:
   - dispense pulses once;
   - credit 70→5;
   - with change_ready=1, exactly one change_5 pulse;
   - IDLE with credit 0, busy low.
2. Credit 40, then cancel with change_ready=1: pulses change_25, change_10, change_5 on consecutive cycles; no dispense; final credit 0.
3. Four pulse_25 (credit 100), then pulse_5: coin_reject pulses; credit stays 100. Then select: dispense; change 35 paid as 25, 10.
4. Refund of 25 with change_ready held 0 for 10 cycles: no change_* pulses and credit holds 25. Raise change_ready: change_25 the next cycle.
5. Credit 60, select: no dispense; credit 60; state CREDIT. Same cycle as a later cancel, assert pulse_10: coin_reject pulses; refund is 60.
6. From IDLE, pulse_10 and pulse_25 in the same cycle: credit 35. With CREDIT_TIMEOUT_EN and TIMEOUT_CYCLES=20, after 20 idle cycles: change_25 then change_10.
